usb_fe_rx: RTL and testbench
============================

Name: usb_fe_rx

Overview:
- Full-speed USB device receive front-end.
- Consumes the raw dp/dn lines driven by the host, either the host bench model or a real PHY.
- Recovers bit timing by 4x oversampling at 48 MHz, detects SYNC, decodes NRZI, removes stuffed bits and detects EOP.
- Delivers received bytes, packet framing strobes and bus-reset detection to the downstream packet decoder.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each dp/dn metastability synchroniser (minimum 2).
- BUS_RESET_CYCLES, 120, consecutive clk cycles of SE0 that declare a bus reset (2.5 us at 48 MHz).

Ports:
- clk, input, 1, 48 MHz system clock (4x the FS bit rate).
- rst_n, input, 1, asynchronous active-low reset.
- dp, input, 1, USB D+ line, asynchronous to clk.
- dn, input, 1, USB D- line, asynchronous to clk.
- line_state, output, 2, synchronised line state: 0 = SE0, 1 = J, 2 = K, 3 = SE1.
- rx_active, output, 1, high from SYNC detection until EOP or error.
- rx_data, output, 8, received byte, assembled LSB first.
- rx_valid, output, 1, one-cycle strobe; rx_data is valid while this is high.
- rx_eop, output, 1, one-cycle strobe at a correctly terminated packet end.
- rx_err, output, 1, one-cycle strobe on a stuff error, SE1, or byte misalignment at EOP.
- usb_reset, output, 1, high while SE0 has persisted for at least BUS_RESET_CYCLES.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All flops use it.
- Reset values:
  - Synchroniser flops reset to J (dp=1, dn=0), so line_state = 1.
  - rx_active, rx_valid, rx_eop, rx_err, usb_reset = 0; rx_data = 8'h00; FSM = IDLE.
  - Asserting rst_n mid-packet drops the packet silently; no rx_err or rx_eop is emitted.
- Bit clock recovery:
  - A 2-bit phase counter increments modulo 4.
  - It is cleared to 0 on any change of the synchronised line state.
  - The sample strobe fires when phase == 2.
  - This tolerates ±1 clk of edge jitter and ±0.25% rate error across a 7-bit run.
- NRZI decode: decoded bit = 1 if the sampled J/K equals the previous sampled J/K, else 0. The previous-state register is J after reset and after EOP.
- FSM states: IDLE, SYNC, DATA, EOP.
  - IDLE: a K sample starts the SYNC search and clears the 8-bit decoded-bit shift register.
  - SYNC:
    - Decoded bits shift in.
    - When the last 8 bits match the SYNC pattern 0,0,0,0,0,0,0,1 (in order received), rx_active is set and the FSM goes to DATA.
    - If SE0 is sampled, or 16 bits pass without a match, the FSM returns to IDLE with no error.
  - DATA, on each strobe:
    - Sampled SE0: go to EOP.
    - Sampled SE1: pulse rx_err, clear rx_active, go to IDLE.
    - Otherwise the decoded bit goes through the unstuffer.
  - Unstuffer:
    - Counts consecutive 1s.
    - After six 1s, the next bit must be 0 and is discarded. If it is 1, pulse rx_err, clear rx_active, go to IDLE.
    - The count resets on any 0, including the discarded stuff bit.
    - The SYNC pattern's trailing 1 counts toward the first run.
  - Byte assembly:
    - Kept bits shift in LSB first, tracked by a 3-bit counter.
    - On the 8th kept bit, rx_data is updated and rx_valid pulses on the clk cycle immediately after that sample strobe.
  - EOP:
    - Waits for the next strobe.
    - SE0 there: keep waiting, up to 2 extra bit times.
    - J there with bit counter == 0: pulse rx_eop.
    - J there with bit counter != 0: pulse rx_err.
    - Either way, clear rx_active the same cycle as the pulse and go to IDLE.
    - K, or SE0 lasting more than 3 bit times: pulse rx_err, go to IDLE.
- Simultaneous strobes:
  - rx_valid and rx_eop/rx_err never coincide; the byte strobe always precedes them by at least 4 cycles.
  - rx_eop and rx_err are mutually exclusive.
- Bus reset detection:
  - A saturating counter counts clk cycles with line_state == SE0 and clears on any other state.
  - usb_reset rises on the cycle the count reaches BUS_RESET_CYCLES and falls the cycle after SE0 ends.
  - A long SE0 during DATA still produces rx_err first.
- Latency: synchroniser delay of SYNC_STAGES clk cycles, plus up to 3 cycles to the sample strobe, plus 1 cycle to the output.

Test Plan:
- Idle J for 20 bit times -> line_state = 1; rx_active, rx_valid, rx_eop, rx_err, usb_reset all stay 0.
- SYNC, then PID byte 0xA5, then SE0 SE0 J, with ±100 ps jitter -> rx_active rises after SYNC; exactly one rx_valid with rx_data = 0xA5; one rx_eop; rx_err = 0.
- SYNC, then 0xFF 0xFF with the host inserting a stuff bit after every six 1s, then EOP -> two rx_valid pulses, each with 0xFF; rx_eop = 1; rx_err = 0.
- SYNC, then seven consecutive 1s (stuff violation) -> one rx_err pulse; rx_active falls; no rx_eop; a following good packet 0x5A is received correctly.
- SYNC, then 12 data bits, then EOP -> one rx_valid (first byte); rx_err pulse at EOP; no rx_eop.
- SE0 held for 3 us -> usb_reset rises exactly 120 clk cycles after SE0 reaches line_state and falls within 1 cycle after J returns. Separately, assert rst_n low mid-byte -> all outputs return to 0 asynchronously and no strobes follow.

Source files
------------

// File: rtl/usb_fe_rx_if.sv
// usb_fe_rx_if: receive bundle from the USB full-speed front-end
// to the packet decoder.
//
// Signals:
//   line_state  synchronised line: 0 SE0, 1 J, 2 K, 3 SE1
//   rx_active   high from SYNC detection until EOP or error
//   rx_data     received byte, LSB first on the wire
//   rx_valid    one-cycle strobe qualifying rx_data
//   rx_eop      one-cycle strobe at a clean packet end
//   rx_err      one-cycle strobe on stuff/SE1/alignment error
//   usb_reset   high while SE0 has lasted long enough
//
// master: the front-end; slave: the packet decoder.
interface usb_fe_rx_if;
   logic [1:0] line_state;
   logic       rx_active;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_eop;
   logic       rx_err;
   logic       usb_reset;

   modport master (
      output line_state,
      output rx_active,
      output rx_data,
      output rx_valid,
      output rx_eop,
      output rx_err,
      output usb_reset
   );

   modport slave (
      input line_state,
      input rx_active,
      input rx_data,
      input rx_valid,
      input rx_eop,
      input rx_err,
      input usb_reset
   );
endinterface

// File: rtl/usb_fe_rx.sv
// usb_fe_rx: full-speed USB device receive front-end.
// 4x oversampled bit recovery, SYNC, NRZI, unstuff, EOP, bus reset.
//
// Ports:
//   clk    48 MHz clock (4x the FS bit rate)
//   rst_n  asynchronous active-low reset
//   dp/dn  raw USB lines, asynchronous to clk
//   rx     usb_fe_rx_if master: line state, bytes, framing, reset
module usb_fe_rx #(
   parameter int SYNC_STAGES      = 2,
   parameter int BUS_RESET_CYCLES = 120
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         dp,
   input  logic         dn,
   usb_fe_rx_if.master  rx
);

   localparam logic [1:0] LS_SE0 = 2'd0;
   localparam logic [1:0] LS_J   = 2'd1;
   localparam logic [1:0] LS_K   = 2'd2;
   localparam logic [1:0] LS_SE1 = 2'd3;

   localparam int RW = $clog2(BUS_RESET_CYCLES + 1);
   localparam logic [RW-1:0] RMAX = RW'(BUS_RESET_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_EOP
   } state_t;

   // ---------------------------------------------------------
   // Metastability synchronisers, idling at J
   // ---------------------------------------------------------
   logic [SYNC_STAGES-1:0] dp_sync;
   logic [SYNC_STAGES-1:0] dn_sync;
   logic [1:0]             line_st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_sync <= '1;
         dn_sync <= '0;
      end else begin
         dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp};
         dn_sync <= {dn_sync[SYNC_STAGES-2:0], dn};
      end
   end

   assign line_st = {dn_sync[SYNC_STAGES-1],
                     dp_sync[SYNC_STAGES-1]};

   // ---------------------------------------------------------
   // Bit clock recovery
   // ---------------------------------------------------------
   // The change cycle counts as phase 0, so phase_q holds 1 on
   // the next cycle and the strobe lands two cycles after each
   // observed edge: mid-bit, with a cycle of margin either way.
   logic [1:0] ls_q;
   logic [1:0] phase_q;
   logic       chg;
   logic       strobe;

   assign chg    = (line_st != ls_q);
   assign strobe = !chg && (phase_q == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ls_q    <= LS_J;
         phase_q <= 2'd0;
      end else begin
         ls_q    <= line_st;
         phase_q <= chg ? 2'd1 : phase_q + 2'd1;
      end
   end

   // ---------------------------------------------------------
   // Receive FSM and datapath
   // ---------------------------------------------------------
   state_t     state_q,  state_n;
   logic       prev_k_q, prev_k_n;
   logic [6:0] sr_q,     sr_n;
   logic [4:0] cnt_q,    cnt_n;
   logic [2:0] ones_q,   ones_n;
   logic [2:0] bit_q,    bit_n;
   logic [6:0] byte_q,   byte_n;
   logic [1:0] se0_q,    se0_n;
   logic [7:0] data_q,   data_n;
   logic       active_q, active_n;
   logic       valid_q,  valid_n;
   logic       eop_q,    eop_n;
   logic       err_q,    err_n;

   logic       is_k;
   logic       is_jk;
   logic       bit_dec;
   logic [7:0] sync_win;
   logic       fail;
   logic       done;

   assign is_k     = (line_st == LS_K);
   assign is_jk    = (line_st == LS_J) || is_k;
   assign bit_dec  = (is_k == prev_k_q);
   assign sync_win = {sr_q, bit_dec};

   always_comb begin
      state_n  = state_q;
      prev_k_n = prev_k_q;
      sr_n     = sr_q;
      cnt_n    = cnt_q;
      ones_n   = ones_q;
      bit_n    = bit_q;
      byte_n   = byte_q;
      se0_n    = se0_q;
      data_n   = data_q;
      active_n = active_q;
      valid_n  = 1'b0;
      eop_n    = 1'b0;
      err_n    = 1'b0;
      fail     = 1'b0;
      done     = 1'b0;

      if (strobe) begin
         unique case (state_q)
            S_IDLE: begin
               // The opening K is already the first SYNC zero.
               if (is_k) begin
                  state_n  = S_SYNC;
                  prev_k_n = 1'b1;
                  sr_n     = '0;
                  cnt_n    = 5'd1;
               end
            end

            S_SYNC: begin
               if (!is_jk) begin
                  state_n  = S_IDLE;
                  prev_k_n = 1'b0;
               end else begin
                  prev_k_n = is_k;
                  sr_n     = sync_win[6:0];
                  cnt_n    = cnt_q + 5'd1;
                  if (cnt_q >= 5'd7 && sync_win == 8'h01) begin
                     state_n  = S_DATA;
                     active_n = 1'b1;
                     // SYNC's trailing 1 opens the first run.
                     ones_n   = 3'd1;
                     bit_n    = 3'd0;
                  end else if (cnt_q == 5'd15) begin
                     state_n  = S_IDLE;
                     prev_k_n = 1'b0;
                  end
               end
            end

            S_DATA: begin
               unique case (line_st)
                  LS_SE0: begin
                     state_n = S_EOP;
                     se0_n   = 2'd1;
                  end
                  LS_SE1: begin
                     fail = 1'b1;
                  end
                  default: begin
                     prev_k_n = is_k;
                     if (ones_q == 3'd6) begin
                        // Stuff bit: must be 0, never kept.
                        if (bit_dec) begin
                           fail = 1'b1;
                        end else begin
                           ones_n = 3'd0;
                        end
                     end else begin
                        ones_n = bit_dec ? ones_q + 3'd1 : 3'd0;
                        byte_n = {bit_dec, byte_q[6:1]};
                        bit_n  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                           data_n  = {bit_dec, byte_q};
                           valid_n = 1'b1;
                        end
                     end
                  end
               endcase
            end

            S_EOP: begin
               unique case (line_st)
                  LS_SE0: begin
                     if (se0_q == 2'd3) begin
                        fail = 1'b1;
                     end else begin
                        se0_n = se0_q + 2'd1;
                     end
                  end
                  LS_J: begin
                     done = 1'b1;
                     if (bit_q == 3'd0) begin
                        eop_n = 1'b1;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  default: begin
                     fail = 1'b1;
                  end
               endcase
            end
         endcase
      end

      if (fail) begin
         err_n = 1'b1;
      end

      if (fail || done) begin
         state_n  = S_IDLE;
         active_n = 1'b0;
         prev_k_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         prev_k_q <= 1'b0;
         sr_q     <= '0;
         cnt_q    <= '0;
         ones_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         se0_q    <= '0;
         data_q   <= 8'h00;
         active_q <= 1'b0;
         valid_q  <= 1'b0;
         eop_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         prev_k_q <= prev_k_n;
         sr_q     <= sr_n;
         cnt_q    <= cnt_n;
         ones_q   <= ones_n;
         bit_q    <= bit_n;
         byte_q   <= byte_n;
         se0_q    <= se0_n;
         data_q   <= data_n;
         active_q <= active_n;
         valid_q  <= valid_n;
         eop_q    <= eop_n;
         err_q    <= err_n;
      end
   end

   // ---------------------------------------------------------
   // Bus reset: saturating SE0 duration counter
   // ---------------------------------------------------------
   logic [RW-1:0] rcnt_q;
   logic [RW-1:0] rcnt_n;
   logic          ureset_q;

   always_comb begin
      rcnt_n = '0;
      if (line_st == LS_SE0) begin
         rcnt_n = (rcnt_q == RMAX) ? rcnt_q : rcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q   <= '0;
         ureset_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_n;
         ureset_q <= (rcnt_n == RMAX);
      end
   end

   // ---------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------
   assign rx.line_state = line_st;
   assign rx.rx_active  = active_q;
   assign rx.rx_data    = data_q;
   assign rx.rx_valid   = valid_q;
   assign rx.rx_eop     = eop_q;
   assign rx.rx_err     = err_q;
   assign rx.usb_reset  = ureset_q;

endmodule

// File: tb/tb_usb_fe_rx.sv
// tb_usb_fe_rx: scoreboard bench for usb_fe_rx.
// Host model drives dp/dn; monitor checks strobes against queue.
`timescale 1ns/1ps
module tb_usb_fe_rx;

   localparam real BIT_NS = 83.336;

   localparam int K_VALID = 0;
   localparam int K_EOP   = 1;
   localparam int K_ERR   = 2;

   typedef bit bitq_t[$];

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic dp    = 1'b1;
   logic dn    = 1'b0;

   usb_fe_rx_if rx_if ();

   usb_fe_rx #(
      .SYNC_STAGES      (2),
      .BUS_RESET_CYCLES (120)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dp    (dp),
      .dn    (dn),
      .rx    (rx_if)
   );

   always #10.417 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   active_seen = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic take(input int kind, input logic [7:0] data);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL spurious strobe: kind %0d data %h, none expected",
                  kind, data);
      end else begin
         e = exp_q.pop_front();
         n_checks--;
         check("strobe kind", kind, e.kind);
         if (kind == K_VALID && e.kind == K_VALID) begin
            check("rx_data", data, e.data);
         end
      end
      check("rx_active at strobe", rx_if.rx_active,
            (kind == K_VALID) ? 1 : 0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_if.rx_active) active_seen = 1'b1;
         if (rx_if.rx_valid) take(K_VALID, rx_if.rx_data);
         if (rx_if.rx_eop)   take(K_EOP, 8'h00);
         if (rx_if.rx_err)   take(K_ERR, 8'h00);
      end
   end

   // Host-side line model
   task automatic drive(input logic [1:0] ls);
      {dn, dp} = ls;
   endtask

   task automatic bit_wait();
      real j;
      j = (real'($urandom_range(0, 200)) - 100.0) * 0.001;
      #(BIT_NS + j);
   endtask

   function automatic bitq_t byte_bits(input logic [7:0] b);
      bitq_t q;
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      return q;
   endfunction

   // Host bit stuffing; SYNC's final 1 starts the run.
   function automatic bitq_t stuff(input bitq_t d);
      bitq_t q;
      int    ones = 1;
      foreach (d[i]) begin
         q.push_back(d[i]);
         ones = d[i] ? ones + 1 : 0;
         if (ones == 6) begin
            q.push_back(1'b0);
            ones = 0;
         end
      end
      return q;
   endfunction

   // Reference: line bits after SYNC -> expected strobes.
   function automatic void model(input bitq_t lb, input int se0_len);
      int         ones = 1;
      int         kept = 0;
      logic [7:0] acc  = 8'h00;
      exp_t       e;
      foreach (lb[i]) begin
         if (ones == 6) begin
            if (lb[i]) begin
               e.kind = K_ERR; e.data = 8'h00;
               exp_q.push_back(e);
               return;
            end
            ones = 0;
         end else begin
            ones = lb[i] ? ones + 1 : 0;
            acc[kept % 8] = lb[i];
            kept++;
            if (kept % 8 == 0) begin
               e.kind = K_VALID; e.data = acc;
               exp_q.push_back(e);
            end
         end
      end
      e.data = 8'h00;
      if (se0_len > 3 || kept % 8 != 0) e.kind = K_ERR;
      else e.kind = K_EOP;
      exp_q.push_back(e);
   endfunction

   task automatic send(input bitq_t lb, input int se0_len);
      bitq_t all;
      bit    k = 1'b0;
      all = byte_bits(8'h80);
      foreach (lb[i]) all.push_back(lb[i]);
      foreach (all[i]) begin
         if (!all[i]) k = ~k;
         drive(k ? 2'd2 : 2'd1);
         bit_wait();
      end
      repeat (se0_len) begin
         drive(2'd0);
         bit_wait();
      end
      drive(2'd1);
      repeat (6) bit_wait();
   endtask

   task automatic run_pkt(input bitq_t lb, input int se0_len,
                          input string name);
      model(lb, se0_len);
      active_seen = 1'b0;
      send(lb, se0_len);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      check({name, " drained"}, exp_q.size(), 0);
      exp_q.delete();
      check({name, " active seen"}, active_seen, 1);
      check({name, " active low"}, rx_if.rx_active, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bitq_t d;
      bitq_t lb;
      int    c;

      // Reset state
      #50;
      check("reset line_state", rx_if.line_state, 1);
      check("reset rx_active", rx_if.rx_active, 0);
      check("reset rx_valid", rx_if.rx_valid, 0);
      check("reset rx_eop", rx_if.rx_eop, 0);
      check("reset rx_err", rx_if.rx_err, 0);
      check("reset usb_reset", rx_if.usb_reset, 0);
      check("reset rx_data", rx_if.rx_data, 0);
      #3.3 rst_n = 1'b1;

      // Idle J
      repeat (20) bit_wait();
      @(negedge clk);
      check("idle line_state", rx_if.line_state, 1);
      check("idle rx_active", rx_if.rx_active, 0);
      check("idle usb_reset", rx_if.usb_reset, 0);

      // PID 0xA5
      run_pkt(stuff(byte_bits(8'hA5)), 2, "pid_a5");

      // 0xFF 0xFF with stuffing
      d = byte_bits(8'hFF);
      d = {d, byte_bits(8'hFF)};
      run_pkt(stuff(d), 2, "ff_ff");

      // Stuff violation, then a good packet
      lb = {};
      repeat (7) lb.push_back(1'b1);
      run_pkt(lb, 2, "stuff_err");
      run_pkt(stuff(byte_bits(8'h5A)), 2, "after_err_5a");

      // 12 data bits -> misaligned EOP
      d = byte_bits(8'h96);
      d = {d, bit'(1), bit'(0), bit'(1), bit'(1)};
      run_pkt(stuff(d), 2, "misalign");

      // Over-long SE0 at EOP
      run_pkt(stuff(byte_bits(8'h3C)), 5, "long_se0");

      // Three-bit-time SE0 is still a clean EOP
      run_pkt(stuff(byte_bits(8'hC3)), 3, "se0_3");

      // Randomised packets
      for (int p = 0; p < 25; p++) begin
         int nb   = $urandom_range(1, 3);
         int mode = $urandom_range(0, 9);
         int se0  = $urandom_range(2, 3);
         d = {};
         for (int b = 0; b < nb; b++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            d = {d, byte_bits(v)};
         end
         if (mode == 0) begin
            int x = $urandom_range(1, 7);
            for (int i = 0; i < x; i++) d.push_back(1'($urandom));
         end
         lb = stuff(d);
         if (mode == 1) repeat (7) lb.push_back(1'b1);
         if (mode == 2) se0 = 5;
         run_pkt(lb, se0, "random");
      end

      // Bus reset: SE0 for ~3 us
      drive(2'd0);
      for (int i = 0; i < 20 && rx_if.line_state != 2'd0; i++)
         @(negedge clk);
      check("se0 reached line_state", rx_if.line_state, 0);
      c = 0;
      while (!rx_if.usb_reset && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("usb_reset delay", c, 120);
      repeat (24) @(negedge clk);
      drive(2'd1);
      for (int i = 0; i < 20 && rx_if.line_state == 2'd0; i++)
         @(negedge clk);
      check("J after bus reset", rx_if.line_state, 1);
      check("usb_reset held", rx_if.usb_reset, 1);
      @(negedge clk);
      check("usb_reset fall", rx_if.usb_reset, 0);
      repeat (8) bit_wait();

      // Asynchronous reset mid-byte
      d = byte_bits(8'h3C);
      d = {d, byte_bits(8'hC3)};
      lb = stuff(d);
      begin
         exp_t e;
         e.kind = K_VALID; e.data = 8'h3C;
         exp_q.push_back(e);
      end
      fork
         send(lb, 2);
         begin
            #(20.0 * BIT_NS + 30.0);
            check("pre-reset byte seen", exp_q.size(), 0);
            check("pre-reset active", rx_if.rx_active, 1);
            rst_n = 1'b0;
            #1;
            check("async rst line_state", rx_if.line_state, 1);
            check("async rst rx_active", rx_if.rx_active, 0);
            check("async rst rx_data", rx_if.rx_data, 0);
            check("async rst rx_valid", rx_if.rx_valid, 0);
            check("async rst rx_eop", rx_if.rx_eop, 0);
            check("async rst rx_err", rx_if.rx_err, 0);
         end
      join
      exp_q.delete();
      #7.1 rst_n = 1'b1;
      repeat (12) bit_wait();
      @(negedge clk);
      check("post-reset active", rx_if.rx_active, 0);
      check("post-reset queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
